// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } ctrlState_t;

  localparam int DEFAULT_MEM_TIMEOUT = 15;
  localparam int DEFAULT_PERF_W      = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clearN,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clearN) begin
    if (!clearN) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer merging load-use, branch and memory wait
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int PERF_W      = DEFAULT_PERF_W
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              loadUseHazard,
  input  logic              branchTaken,
  input  logic              memAccess,
  input  logic              memReady,
  input  logic              errorAck,
  output logic              pcWrite,
  output logic              ifIdWrite,
  output logic              ifIdFlush,
  output logic              idExFlush,
  output logic              pipeHold,
  output logic              memWbFlush,
  output logic              pcTrap,
  output logic              memError,
  output logic [PERF_W-1:0] stallCycles
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  ctrlState_t state, stateNext;
  logic [7:0] waitCnt, waitCntNext;
  logic       doFreeze;
  logic       doResolve;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= ST_RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    doFreeze    = 1'b0;
    doResolve   = 1'b0;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    pipeHold    = 1'b0;
    memWbFlush  = 1'b0;
    pcTrap      = 1'b0;
    memError    = 1'b0;

    case (state)
      ST_RUN: begin
        if (memAccess && !memReady) begin
          doFreeze    = 1'b1;
          stateNext   = ST_MEM_WAIT;
          waitCntNext = 8'd1;
        end else begin
          doResolve = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (memReady) begin
          doResolve   = 1'b1;
          stateNext   = ST_RUN;
          waitCntNext = '0;
        end else if (waitCnt == TIMEOUT) begin
          doFreeze  = 1'b1;
          stateNext = ST_ERROR;
        end else begin
          doFreeze    = 1'b1;
          waitCntNext = waitCnt + 8'd1;
        end
      end
      ST_ERROR: begin
        memError   = 1'b1;
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        pipeHold   = 1'b1;
        memWbFlush = 1'b1;
        if (errorAck) begin
          pcWrite     = 1'b1;
          pcTrap      = 1'b1;
          ifIdFlush   = 1'b1;
          idExFlush   = 1'b1;
          pipeHold    = 1'b0;
          stateNext   = ST_RUN;
          waitCntNext = '0;
        end
      end
      default: begin
        stateNext   = ST_RUN;
        waitCntNext = '0;
      end
    endcase

    if (doFreeze) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      pipeHold   = 1'b1;
      memWbFlush = 1'b1;
    end

    // A taken branch squashes the wrong-path load-use request behind it
    if (doResolve) begin
      if (branchTaken) begin
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
      end else if (loadUseHazard) begin
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
        idExFlush = 1'b1;
      end
    end

    // Outputs snap to their idle values while reset is held, without waiting for a clock
    if (!resetN) begin
      pcWrite    = 1'b1;
      ifIdWrite  = 1'b1;
      ifIdFlush  = 1'b0;
      idExFlush  = 1'b0;
      pipeHold   = 1'b0;
      memWbFlush = 1'b0;
      pcTrap     = 1'b0;
      memError   = 1'b0;
    end
  end

  sat_counter #(
    .W(PERF_W)
  ) uStallCounter (
    .clk    (clk),
    .clearN (resetN),
    .enable (!pcWrite),
    .count  (stallCycles)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed vectors and sequences for pipeline_stall_controller
module tb_pipeline_stall_controller;

  logic clk;
  logic resetN;
  logic loadUseHazard, branchTaken, memAccess, memReady, errorAck;

  logic dPcWrite, dIfIdWrite, dIfIdFlush, dIdExFlush, dPipeHold, dMemWbFlush, dPcTrap, dMemError;
  logic sPcWrite, sIfIdWrite, sIfIdFlush, sIdExFlush, sPipeHold, sMemWbFlush, sPcTrap, sMemError;
  logic [15:0] dStall;
  logic [3:0]  sStall;
  logic [7:0]  dOut, sOut;

  int testsRun = 0;
  int failCount = 0;

  pipeline_stall_controller dut (
    .clk(clk), .resetN(resetN),
    .loadUseHazard(loadUseHazard), .branchTaken(branchTaken),
    .memAccess(memAccess), .memReady(memReady), .errorAck(errorAck),
    .pcWrite(dPcWrite), .ifIdWrite(dIfIdWrite), .ifIdFlush(dIfIdFlush),
    .idExFlush(dIdExFlush), .pipeHold(dPipeHold), .memWbFlush(dMemWbFlush),
    .pcTrap(dPcTrap), .memError(dMemError), .stallCycles(dStall)
  );

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .PERF_W(4)) dutSmall (
    .clk(clk), .resetN(resetN),
    .loadUseHazard(loadUseHazard), .branchTaken(branchTaken),
    .memAccess(memAccess), .memReady(memReady), .errorAck(errorAck),
    .pcWrite(sPcWrite), .ifIdWrite(sIfIdWrite), .ifIdFlush(sIfIdFlush),
    .idExFlush(sIdExFlush), .pipeHold(sPipeHold), .memWbFlush(sMemWbFlush),
    .pcTrap(sPcTrap), .memError(sMemError), .stallCycles(sStall)
  );

  // {pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeHold, memWbFlush, pcTrap, memError}
  assign dOut = {dPcWrite, dIfIdWrite, dIfIdFlush, dIdExFlush, dPipeHold, dMemWbFlush, dPcTrap, dMemError};
  assign sOut = {sPcWrite, sIfIdWrite, sIfIdFlush, sIdExFlush, sPipeHold, sMemWbFlush, sPcTrap, sMemError};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       lu;
    logic       br;
    logic       ma;
    logic       mr;
    logic       ack;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setIn(input logic lu, input logic br, input logic ma, input logic mr, input logic ack);
    loadUseHazard = lu;
    branchTaken   = br;
    memAccess     = ma;
    memReady      = mr;
    errorAck      = ack;
  endtask

  task automatic pulseReset();
    resetN = 1'b0;
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    vecs[0]  = {5'b00000, 8'b1100_0000};
    vecs[1]  = {5'b10000, 8'b0001_0000};
    vecs[2]  = {5'b01000, 8'b1111_0000};
    vecs[3]  = {5'b11000, 8'b1111_0000};
    vecs[4]  = {5'b00100, 8'b0000_1100};
    vecs[5]  = {5'b11100, 8'b0000_1100};
    vecs[6]  = {5'b00110, 8'b1100_0000};
    vecs[7]  = {5'b01110, 8'b1111_0000};
    vecs[8]  = {5'b00010, 8'b1100_0000};
    vecs[9]  = {5'b00001, 8'b1100_0000};
    vecs[10] = {5'b10110, 8'b0001_0000};

    resetN = 1'b0;
    setIn(0, 0, 0, 0, 0);
    #12;
    check("reset_out_d", dOut, 8'b1100_0000);
    check("reset_out_s", sOut, 8'b1100_0000);
    check("reset_stall_d", dStall, 0);
    check("reset_stall_s", sStall, 0);
    resetN = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      pulseReset();
      setIn(vecs[i].lu, vecs[i].br, vecs[i].ma, vecs[i].mr, vecs[i].ack);
      #1;
      check($sformatf("vec%0d_out_d", i), dOut, vecs[i].expOut);
      check($sformatf("vec%0d_out_s", i), sOut, vecs[i].expOut);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_stall_d", i), dStall, vecs[i].expOut[7] ? 0 : 1);
      check($sformatf("vec%0d_stall_s", i), sStall, vecs[i].expOut[7] ? 0 : 1);
    end

    // memory wait with a branch held in EX, then ready
    @(negedge clk);
    pulseReset();
    setIn(0, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("memwait_frozen%0d", k), dOut, 8'b0000_1100);
      @(negedge clk);
    end
    memReady = 1'b1;
    #1;
    check("memwait_ready_d", dOut, 8'b1111_0000);
    check("memwait_ready_s", sOut, 8'b1111_0000);
    @(posedge clk);
    #1;
    check("memwait_stall_d", dStall, 3);
    check("memwait_stall_s", sStall, 3);
    @(negedge clk);
    setIn(0, 0, 0, 0, 0);
    #1;
    check("memwait_after", dOut, 8'b1100_0000);

    // timeout into ERROR on the small instance, then acknowledge
    @(negedge clk);
    pulseReset();
    setIn(0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("timeout_frozen%0d", k), sOut, 8'b0000_1100);
      @(negedge clk);
    end
    #1;
    check("error_hold_s", sOut, 8'b0000_1101);
    check("error_wait_d", dOut, 8'b0000_1100);
    @(negedge clk);
    errorAck = 1'b1;
    #1;
    check("error_ack_s", sOut, 8'b1011_0111);
    check("error_ack_ignored_d", dOut, 8'b0000_1100);
    @(posedge clk);
    #1;
    check("error_stall_s", sStall, 6);
    check("error_stall_d", dStall, 7);
    @(negedge clk);
    setIn(0, 0, 0, 0, 0);
    #1;
    check("error_exit_s", sOut, 8'b1100_0000);
    // default instance still in MEM_WAIT; reset must bring it back to RUN with no clock edge
    check("memwait_held_d", dOut, 8'b0000_1100);
    pulseReset();
    #1;
    check("memwait_reset_d", dOut, 8'b1100_0000);
    check("memwait_reset_stall_d", dStall, 0);

    // saturation of the narrow counter, then asynchronous reset mid-stall
    @(negedge clk);
    pulseReset();
    setIn(1, 0, 0, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("sat_stall_s", sStall, 15);
    check("sat_stall_d", dStall, 20);
    #2;
    resetN = 1'b0;
    #1;
    check("async_stall_s", sStall, 0);
    check("async_stall_d", dStall, 0);
    check("async_pcwrite_s", sPcWrite, 1);
    check("async_pcwrite_d", dPcWrite, 1);
    resetN = 1'b1;
    setIn(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
